io_port_bank: RTL and testbench



---
 rtl/io_port_bank_if.sv | 30 +++
 rtl/io_port_bank.sv | 121 ++++++++++++
 tb/tb_io_port_bank.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_port_bank_if.sv
// CPU I/O bus between the bus bridge and the I/O port bank.
// Strobes are single-cycle and never stall; oCpuSel is the read-data-valid qualifier.
interface io_port_bank_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] iCpuAddr;
    logic [7:0]        iCpuData;
    logic              iCpuIoRd;
    logic              iCpuIoWr;
    logic [7:0]        oCpuData;
    logic              oCpuSel;

    modport master (
        output iCpuAddr,
        output iCpuData,
        output iCpuIoRd,
        output iCpuIoWr,
        input  oCpuData,
        input  oCpuSel
    );

    modport slave (
        input  iCpuAddr,
        input  iCpuData,
        input  iCpuIoRd,
        input  iCpuIoWr,
        output oCpuData,
        output oCpuSel
    );
endinterface

// File: rtl/io_port_bank.sv
// Bank of readable output latches and synchronised input ports with
// change-detect status, read-to-clear and a maskable registered interrupt.
module io_port_bank #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE      = 16'h0028,
    parameter int                NUM_OUT   = 4,
    parameter int                NUM_IN    = 2,
    parameter logic [7:0]        OUT_RESET = 8'h00
) (
    input  logic                  iClk,
    input  logic                  iReset,
    io_port_bank_if.slave         bus,
    output logic [NUM_OUT*8-1:0]  oPort,
    input  logic [NUM_IN*8-1:0]   iPort,
    output logic                  oIrq
);

    localparam int                SPAN       = NUM_OUT + NUM_IN + 2;
    localparam logic [ADDR_W-1:0] OFF_IN     = ADDR_W'(NUM_OUT);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(NUM_OUT + NUM_IN);
    localparam logic [ADDR_W-1:0] OFF_MASK   = ADDR_W'(NUM_OUT + NUM_IN + 1);
    localparam logic [ADDR_W-1:0] OFF_END    = ADDR_W'(SPAN);

    logic [NUM_OUT-1:0][7:0] out_q, out_d;
    logic [NUM_IN-1:0][7:0]  s1_q, s2_q, prev_q;
    logic [NUM_IN-1:0]       status_q, status_d;
    logic [NUM_IN-1:0]       mask_q, mask_d;
    logic [7:0]              data_q, data_d;
    logic                    sel_q, sel_d;
    logic                    irq_q, irq_d;

    logic [ADDR_W-1:0]       off;
    logic                    hit;
    logic                    rd_en;
    logic                    wr_en;
    logic [7:0]              rd_val;
    logic [NUM_IN-1:0]       chg;
    logic [NUM_IN-1:0]       clr;

    // Below-BASE addresses wrap to large offsets and so fall outside the span.
    assign off   = bus.iCpuAddr - BASE;
    assign hit   = (off < OFF_END);
    assign rd_en = bus.iCpuIoRd & hit;
    assign wr_en = bus.iCpuIoWr & hit;

    always_comb begin
        chg = '0;
        for (int n = 0; n < NUM_IN; n++) begin
            chg[n] = (s2_q[n] != prev_q[n]);
        end
    end

    // Read mux sees pre-edge register values, so rd+wr on one offset returns old data.
    always_comb begin
        rd_val = 8'h00;
        for (int n = 0; n < NUM_OUT; n++) begin
            if (off == ADDR_W'(n)) rd_val = out_q[n];
        end
        for (int n = 0; n < NUM_IN; n++) begin
            if (off == OFF_IN + ADDR_W'(n)) rd_val = s2_q[n];
        end
        if (off == OFF_STATUS) rd_val = 8'(status_q);
        if (off == OFF_MASK)   rd_val = 8'(mask_q);
    end

    always_comb begin
        out_d    = out_q;
        mask_d   = mask_q;
        data_d   = data_q;
        sel_d    = 1'b0;
        clr      = '0;
        status_d = status_q;
        irq_d    = |(status_q & mask_q);

        if (rd_en) begin
            data_d = rd_val;
            sel_d  = 1'b1;
            if (off == OFF_STATUS) clr = status_q;
        end

        // Set wins over clear when a change lands on the clearing read.
        status_d = (status_q & ~clr) | chg;

        if (wr_en) begin
            for (int n = 0; n < NUM_OUT; n++) begin
                if (off == ADDR_W'(n)) out_d[n] = bus.iCpuData;
            end
            if (off == OFF_MASK) mask_d = bus.iCpuData[NUM_IN-1:0];
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            out_q    <= {NUM_OUT{OUT_RESET}};
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            status_q <= '0;
            mask_q   <= '0;
            data_q   <= 8'h00;
            sel_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            s1_q     <= iPort;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            status_q <= status_d;
            mask_q   <= mask_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            irq_q    <= irq_d;
        end
    end

    assign oPort        = out_q;
    assign oIrq         = irq_q;
    assign bus.oCpuData = data_q;
    assign bus.oCpuSel  = sel_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed vector table, history-based reference
// model with a scoreboard queue, randomized traffic and a mid-access reset.
module tb_io_port_bank;

  localparam int NUM_OUT = 4;
  localparam int NUM_IN  = 2;
  localparam int BASE    = 'h0028;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] o_port;
  logic [15:0] i_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  io_port_bank_if #(.ADDR_W(16)) bus ();

  io_port_bank dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus),
    .oPort  (o_port),
    .iPort  (i_port),
    .oIrq   (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Input ports are modelled as a history of the values present at the last
  // three edges: the register view is the value seen two edges back, and a
  // change is reported when it differs from the one before that.
  logic [7:0]  m_out [NUM_OUT];
  logic [1:0]  m_mask;
  logic [1:0]  m_status;
  logic [7:0]  m_data;
  logic        m_sel;
  logic        m_irq;
  logic [15:0] hist [$];
  logic [41:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < NUM_OUT; i++) m_out[i] = 8'h00;
    m_mask   = 2'b00;
    m_status = 2'b00;
    m_data   = 8'h00;
    m_sel    = 1'b0;
    m_irq    = 1'b0;
    hist     = '{16'h0000, 16'h0000, 16'h0000};
    exp_q.delete();
  endtask

  task automatic model_step();
    int          off;
    bit          in_span;
    logic [15:0] seen;
    logic [15:0] older;
    logic [1:0]  chg;
    logic [7:0]  rv;
    logic        nirq;
    off     = int'(bus.iCpuAddr) - BASE;
    in_span = (off >= 0) && (off < NUM_OUT + NUM_IN + 2);
    seen    = hist[1];
    older   = hist[0];
    chg[0]  = (seen[7:0]  != older[7:0]);
    chg[1]  = (seen[15:8] != older[15:8]);
    rv = 8'h00;
    if (off >= 0 && off < NUM_OUT) rv = m_out[off];
    else if (off == 4)             rv = seen[7:0];
    else if (off == 5)             rv = seen[15:8];
    else if (off == 6)             rv = {6'b0, m_status};
    else if (off == 7)             rv = {6'b0, m_mask};
    nirq  = |(m_status & m_mask);
    m_sel = bus.iCpuIoRd && in_span;
    if (m_sel) m_data = rv;
    if (m_sel && off == 6) m_status = 2'b00;
    m_status = m_status | chg;
    if (bus.iCpuIoWr && in_span) begin
      if (off < NUM_OUT) m_out[off] = bus.iCpuData;
      else if (off == 7) m_mask = bus.iCpuData[1:0];
    end
    m_irq = nirq;
    hist.push_back(i_port);
    void'(hist.pop_front());
    exp_q.push_back({m_out[3], m_out[2], m_out[1], m_out[0], m_sel, m_data, m_irq});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one bus cycle, scoreboard compare after the edge
  task automatic cycle();
    logic [41:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("model_port", o_port, e[41:10]);
    check("model_sel",  {31'b0, bus.oCpuSel}, {31'b0, e[9]});
    check("model_data", {24'b0, bus.oCpuData}, {24'b0, e[8:1]});
    check("model_irq",  {31'b0, irq}, {31'b0, e[0]});
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [7:0] wd);
    bus.iCpuIoRd = rd;
    bus.iCpuIoWr = wr;
    bus.iCpuAddr = addr;
    bus.iCpuData = wd;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [15:0] port;
    logic        sel;
    logic [7:0]  data;
    logic        irq;
    logic [31:0] oport;
  } vec_t;

  localparam int NV = 41;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [7:0] wd, input logic [15:0] port, input logic sel,
                              input logic [7:0] data, input logic irq, input logic [31:0] oport);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.port = port;
    v.sel = sel; v.data = data; v.irq = irq; v.oport = oport;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(1, 0, 16'h002E, 8'h00, 16'h0000, 1, 8'h00, 0, 32'h0000_0000);
    vecs[1]  = mk(0, 0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 32'h0000_0000);
    vecs[2]  = mk(0, 1, 16'h0029, 8'hA5, 16'h0000, 0, 8'h00, 0, 32'h0000_A500);
    vecs[3]  = mk(1, 0, 16'h0029, 8'h00, 16'h0000, 1, 8'hA5, 0, 32'h0000_A500);
    vecs[4]  = mk(0, 1, 16'h002F, 8'h01, 16'h0000, 0, 8'hA5, 0, 32'h0000_A500);
    vecs[5]  = mk(0, 0, 16'h0000, 8'h00, 16'h003C, 0, 8'hA5, 0, 32'h0000_A500);
    vecs[6]  = mk(0, 0, 16'h0000, 8'h00, 16'h003C, 0, 8'hA5, 0, 32'h0000_A500);
    vecs[7]  = mk(0, 0, 16'h0000, 8'h00, 16'h003C, 0, 8'hA5, 0, 32'h0000_A500);
    vecs[8]  = mk(0, 0, 16'h0000, 8'h00, 16'h003C, 0, 8'hA5, 1, 32'h0000_A500);
    vecs[9]  = mk(1, 0, 16'h002C, 8'h00, 16'h003C, 1, 8'h3C, 1, 32'h0000_A500);
    vecs[10] = mk(1, 0, 16'h002E, 8'h00, 16'h003C, 1, 8'h01, 1, 32'h0000_A500);
    vecs[11] = mk(0, 0, 16'h0000, 8'h00, 16'h003C, 0, 8'h01, 0, 32'h0000_A500);
    vecs[12] = mk(1, 0, 16'h002E, 8'h00, 16'h003C, 1, 8'h00, 0, 32'h0000_A500);
    vecs[13] = mk(0, 0, 16'h0000, 8'h00, 16'h003D, 0, 8'h00, 0, 32'h0000_A500);
    vecs[14] = mk(0, 0, 16'h0000, 8'h00, 16'h003D, 0, 8'h00, 0, 32'h0000_A500);
    vecs[15] = mk(0, 0, 16'h0000, 8'h00, 16'h003D, 0, 8'h00, 0, 32'h0000_A500);
    vecs[16] = mk(0, 0, 16'h0000, 8'h00, 16'h003D, 0, 8'h00, 1, 32'h0000_A500);
    vecs[17] = mk(0, 0, 16'h0000, 8'h00, 16'h553D, 0, 8'h00, 1, 32'h0000_A500);
    vecs[18] = mk(0, 0, 16'h0000, 8'h00, 16'h553D, 0, 8'h00, 1, 32'h0000_A500);
    vecs[19] = mk(1, 0, 16'h002E, 8'h00, 16'h553D, 1, 8'h01, 1, 32'h0000_A500);
    vecs[20] = mk(0, 0, 16'h0000, 8'h00, 16'h553D, 0, 8'h01, 0, 32'h0000_A500);
    vecs[21] = mk(1, 0, 16'h002E, 8'h00, 16'h553D, 1, 8'h02, 0, 32'h0000_A500);
    vecs[22] = mk(1, 0, 16'h0030, 8'h00, 16'h553D, 0, 8'h02, 0, 32'h0000_A500);
    vecs[23] = mk(0, 1, 16'h0027, 8'hFF, 16'h553D, 0, 8'h02, 0, 32'h0000_A500);
    vecs[24] = mk(1, 1, 16'h0030, 8'h5A, 16'h553D, 0, 8'h02, 0, 32'h0000_A500);
    vecs[25] = mk(0, 1, 16'h0028, 8'h11, 16'h553D, 0, 8'h02, 0, 32'h0000_A511);
    vecs[26] = mk(1, 1, 16'h0028, 8'h22, 16'h553D, 1, 8'h11, 0, 32'h0000_A522);
    vecs[27] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h11, 0, 32'h0000_A522);
    vecs[28] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h11, 0, 32'h0000_A522);
    vecs[29] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h11, 0, 32'h0000_A522);
    vecs[30] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h11, 1, 32'h0000_A522);
    vecs[31] = mk(0, 1, 16'h002F, 8'h00, 16'h5500, 0, 8'h11, 1, 32'h0000_A522);
    vecs[32] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h11, 0, 32'h0000_A522);
    vecs[33] = mk(1, 0, 16'h002F, 8'h00, 16'h5500, 1, 8'h00, 0, 32'h0000_A522);
    vecs[34] = mk(0, 1, 16'h002F, 8'hFF, 16'h5500, 0, 8'h00, 0, 32'h0000_A522);
    vecs[35] = mk(1, 0, 16'h002F, 8'h00, 16'h5500, 1, 8'h03, 1, 32'h0000_A522);
    vecs[36] = mk(0, 1, 16'h002C, 8'h77, 16'h5500, 0, 8'h03, 1, 32'h0000_A522);
    vecs[37] = mk(1, 0, 16'h002C, 8'h00, 16'h5500, 1, 8'h00, 1, 32'h0000_A522);
    vecs[38] = mk(1, 0, 16'h002D, 8'h00, 16'h5500, 1, 8'h55, 1, 32'h0000_A522);
    vecs[39] = mk(1, 0, 16'h002E, 8'h00, 16'h5500, 1, 8'h01, 1, 32'h0000_A522);
    vecs[40] = mk(0, 0, 16'h0000, 8'h00, 16'h5500, 0, 8'h01, 0, 32'h0000_A522);

    // reset state
    rst    = 1'b1;
    i_port = 16'h0000;
    drive(0, 0, 16'h0000, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_port", o_port, 32'h0000_0000);
    check("reset_sel",  {31'b0, bus.oCpuSel}, 32'd0);
    check("reset_data", {24'b0, bus.oCpuData}, 32'd0);
    check("reset_irq",  {31'b0, irq}, 32'd0);
    rst = 1'b0;
    model_reset();

    // directed table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd);
      i_port = vecs[i].port;
      cycle();
      check($sformatf("vec%0d_port", i), o_port, vecs[i].oport);
      check($sformatf("vec%0d_sel", i),  {31'b0, bus.oCpuSel}, {31'b0, vecs[i].sel});
      check($sformatf("vec%0d_data", i), {24'b0, bus.oCpuData}, {24'b0, vecs[i].data});
      check($sformatf("vec%0d_irq", i),  {31'b0, irq}, {31'b0, vecs[i].irq});
    end

    // randomized traffic around the decoded span
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
            16'h0026 + 16'($urandom_range(0, 11)), 8'($urandom));
      if ($urandom_range(0, 7) == 0) i_port = 16'($urandom);
      cycle();
    end

    // reset asserted in the middle of a write/read
    drive(1, 1, 16'h0028, 8'h99);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_port", o_port, 32'h0000_0000);
    check("midrst_sel",  {31'b0, bus.oCpuSel}, 32'd0);
    check("midrst_data", {24'b0, bus.oCpuData}, 32'd0);
    check("midrst_irq",  {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_nowrite", o_port, 32'h0000_0000);
    check("midrst_sel2",    {31'b0, bus.oCpuSel}, 32'd0);
    drive(0, 0, 16'h0000, 8'h00);
    i_port = 16'hC300;
    rst    = 1'b0;
    model_reset();

    // nonzero input at reset release must raise STATUS and, once unmasked, the irq
    drive(0, 1, 16'h002F, 8'h03);
    cycle();
    drive(0, 0, 16'h0000, 8'h00);
    repeat (4) cycle();
    check("release_irq", {31'b0, irq}, 32'd1);
    drive(1, 0, 16'h002E, 8'h00);
    cycle();
    check("release_status", {24'b0, bus.oCpuData}, 32'h0000_0002);
    drive(1, 0, 16'h002D, 8'h00);
    cycle();
    check("release_in1", {24'b0, bus.oCpuData}, 32'h0000_00C3);
    drive(0, 0, 16'h0000, 8'h00);
    repeat (2) cycle();
    check("release_irq_clr", {31'b0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
